// File: rtl/clk_div_bank_pkg.sv
// rtl/clk_div_bank_pkg.sv - shared constants, types and ratio clamp for clk_div_bank
package clk_div_bank_pkg;

  localparam int MIN_DIV   = 2;
  localparam int DEF_DIV_W = 8;

  typedef logic [DEF_DIV_W-1:0] div_t;

  // Width-agnostic so channels with a non-default DIV_W can share it.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/clk_div_bank_chan.sv
// rtl/clk_div_bank_chan.sv - one divider channel: counter, ratio staging, output register, lock flag
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = MIN_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic             o_pending,
  output logic             o_clk,
  output logic             o_locked
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_nxt_div;
  logic             r_pending;
  logic             r_en_q;
  logic             r_clk;
  logic             r_locked;

  logic [DIV_W-1:0] w_half;
  logic             w_wrap;
  logic             w_first;

  assign w_half  = r_div >> 1;
  assign w_wrap  = (r_cnt == r_div - ONE);
  assign w_first = i_en & ~r_en_q;

  // Ratio changes only land where cnt restarts at 0, so no runt pulse is possible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_nxt_div <= DIV_W'(DEFAULT_DIV);
      r_pending <= 1'b0;
      r_en_q    <= 1'b0;
      r_clk     <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_en_q <= i_en;
      if (i_wr) begin
        r_nxt_div <= DIV_W'(clamp_div(32'(i_wr_div)));
        r_pending <= 1'b1;
      end
      if (!i_en) begin
        r_cnt    <= '0;
        r_clk    <= 1'b0;
        r_locked <= 1'b0;
      end else if (i_sync) begin
        if (r_pending) begin
          r_div     <= r_nxt_div;
          r_pending <= 1'b0;
        end
        r_cnt    <= '0;
        r_clk    <= 1'b0;
        r_locked <= 1'b0;
      end else if (w_wrap) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        if (r_pending) begin
          r_div     <= r_nxt_div;
          r_pending <= 1'b0;
          r_locked  <= 1'b0;
        end else begin
          r_locked <= 1'b1;
        end
      end else begin
        // cnt is 0 on the first enabled cycle, so the high phase starts regardless of ratio.
        if (w_first && r_pending) begin
          r_div     <= r_nxt_div;
          r_pending <= 1'b0;
        end
        r_clk <= (r_cnt < w_half);
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_clk     = r_clk;
  assign o_locked  = r_locked;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of NUM_CH programmable clock dividers with a valid/ready ratio port
// Optional CLK_DIV_BANK_SYNC_EN adds sync_restart for phase-aligned restart of all channels.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  DIV_W       = DEF_DIV_W,
  parameter int  DEFAULT_DIV = 2,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic              sync_restart,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] outclk,
  output logic              rdclk,
  output logic              wrclk,
  output logic [NUM_CH-1:0] locked
);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_ready;
  logic              w_sync;

`ifdef CLK_DIV_BANK_SYNC_EN
  assign w_sync = sync_restart;
`else
  assign w_sync = 1'b0;
`endif

  // Out-of-range channel numbers match nothing: ready stays high and the write is dropped.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) w_ready = ~w_pending[i];
    end
  end

  assign cfg_ready = w_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign w_wr[g] = cfg_valid & w_ready & (cfg_ch == CH_W'(g));

    clk_div_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_en     (en[g]),
      .i_sync   (w_sync),
      .i_wr     (w_wr[g]),
      .i_wr_div (cfg_div),
      .o_pending(w_pending[g]),
      .o_clk    (outclk[g]),
      .o_locked (locked[g])
    );
  end

  assign rdclk = outclk[0];
  assign wrclk = outclk[NUM_CH-1];

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed vector bench for clk_div_bank (4 channels, default ratio 2)
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en = 4'b0000;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic [3:0] outclk;
  logic       rdclk;
  logic       wrclk;
  logic [3:0] locked;
`ifdef CLK_DIV_BANK_SYNC_EN
  logic       sync_restart = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] en;
    logic       v;
    logic [1:0] ch;
    logic [7:0] div;
    logic [3:0] exp_clk;
    logic [3:0] exp_lock;
    logic       exp_rdy;
  } vec_t;

  vec_t tbl[24];

  clk_div_bank #(
    .NUM_CH     (4),
    .DIV_W      (8),
    .DEFAULT_DIV(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
`ifdef CLK_DIV_BANK_SYNC_EN
    .sync_restart(sync_restart),
`endif
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .outclk      (outclk),
    .rdclk       (rdclk),
    .wrclk       (wrclk),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat7;

    tbl[0]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b1111, 4'b0000, 1'b1};
    tbl[1]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b1111, 1'b1};
    tbl[2]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b1111, 4'b1111, 1'b1};
    tbl[3]  = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b0000, 4'b1111, 1'b1};
    tbl[4]  = '{4'hF, 1'b1, 2'd1, 8'd5, 4'b1111, 4'b1111, 1'b0};
    tbl[5]  = '{4'hF, 1'b0, 2'd1, 8'd0, 4'b0000, 4'b1101, 1'b1};
    tbl[6]  = '{4'hF, 1'b0, 2'd1, 8'd0, 4'b1111, 4'b1101, 1'b1};
    tbl[7]  = '{4'hF, 1'b0, 2'd1, 8'd0, 4'b0010, 4'b1101, 1'b1};
    tbl[8]  = '{4'hF, 1'b0, 2'd1, 8'd0, 4'b1101, 4'b1101, 1'b1};
    tbl[9]  = '{4'hF, 1'b0, 2'd1, 8'd0, 4'b0000, 4'b1101, 1'b1};
    tbl[10] = '{4'hF, 1'b0, 2'd1, 8'd0, 4'b1101, 4'b1111, 1'b1};
    tbl[11] = '{4'hF, 1'b1, 2'd2, 8'd0, 4'b0010, 4'b1111, 1'b0};
    tbl[12] = '{4'hF, 1'b1, 2'd2, 8'd3, 4'b1111, 4'b1111, 1'b0};
    tbl[13] = '{4'hF, 1'b1, 2'd2, 8'd3, 4'b0000, 4'b1011, 1'b1};
    tbl[14] = '{4'hF, 1'b1, 2'd2, 8'd3, 4'b1101, 4'b1011, 1'b0};
    tbl[15] = '{4'hF, 1'b0, 2'd2, 8'd0, 4'b0000, 4'b1011, 1'b1};
    tbl[16] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b1111, 4'b1011, 1'b1};
    tbl[17] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b0010, 4'b1011, 1'b1};
    tbl[18] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b1001, 4'b1111, 1'b1};
    tbl[19] = '{4'h7, 1'b0, 2'd0, 8'd0, 4'b0100, 4'b0111, 1'b1};
    tbl[20] = '{4'h7, 1'b0, 2'd0, 8'd0, 4'b0001, 4'b0111, 1'b1};
    tbl[21] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b1010, 4'b0111, 1'b1};
    tbl[22] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b0111, 4'b1111, 1'b1};
    tbl[23] = '{4'hF, 1'b0, 2'd0, 8'd0, 4'b1000, 4'b1111, 1'b1};

    step();
    step();
    chk("reset_outclk", 16'(outclk), 16'h0);
    chk("reset_locked", 16'(locked), 16'h0);
    chk("reset_ready", 16'(cfg_ready), 16'h1);
    chk("reset_alias", 16'({rdclk, wrclk}), 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      en        = tbl[i].en;
      cfg_valid = tbl[i].v;
      cfg_ch    = tbl[i].ch;
      cfg_div   = tbl[i].div;
      step();
      chk($sformatf("vec%0d", i + 1),
          16'({outclk, locked, cfg_ready, rdclk, wrclk}),
          16'({tbl[i].exp_clk, tbl[i].exp_lock, tbl[i].exp_rdy,
               tbl[i].exp_clk[0], tbl[i].exp_clk[3]}));
    end

    // ch0 to ratio 7: high 3, low 4 after the apply at its next wrap
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7;
    step();
    chk("r7_ready_low", 16'(cfg_ready), 16'h0);
    cfg_valid = 1'b0;
    step();
    chk("r7_apply", 16'({outclk[0], locked[0]}), 16'h0);
    pat7 = 8'b1110_0001;
    for (int j = 0; j < 8; j++) begin
      step();
      chk($sformatf("r7_cyc%0d", j), 16'(outclk[0]), 16'(pat7[7-j]));
    end
    chk("r7_locked", 16'(locked[0]), 16'h1);

    // pending update on ch0, then async reset mid high phase
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step();
    chk("rst_pre_state", 16'({outclk[0], cfg_ready}), 16'b10);
    cfg_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_async_outclk", 16'(outclk), 16'h0);
    chk("rst_async_locked", 16'(locked), 16'h0);
    chk("rst_async_alias", 16'({rdclk, wrclk}), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pending_cleared", 16'(cfg_ready), 16'h1);
    step();
    chk("rst_restart_hi", 16'(outclk), 16'hF);
    step();
    chk("rst_ratio2_lo", 16'({outclk, locked}), 16'h0F);
    step();
    chk("rst_ratio2_hi", 16'(outclk), 16'hF);

`ifdef CLK_DIV_BANK_SYNC_EN
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
    step();
    cfg_ch = 2'd1; cfg_div = 8'd6;
    step();
    cfg_valid = 1'b0;
    repeat (12) step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
    step();
    chk("sync_pending", 16'(cfg_ready), 16'h0);
    cfg_valid = 1'b0;
    sync_restart = 1'b1;
    step();
    chk("sync_edge", 16'({outclk, locked, cfg_ready}), 16'b0000_0000_1);
    sync_restart = 1'b0;
    step();
    chk("sync_rise", 16'(outclk), 16'hF);
    step();
    chk("sync_p2", 16'(outclk), 16'b0001);
    step();
    chk("sync_p3", 16'(outclk), 16'b1100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
